boron_key_sched: RTL
====================

BORON_KEY_SCHED -- requirements
Module: boron_key_sched

Interface
REQ-001 SHALL have parameter KEY_W, default 128, master key width; legal values 80 and 128 only.
REQ-002 SHALL have parameter NR, default 25, index of the last round key; legal range 1..31.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port key_in, input, KEY_W, master key, sampled on key handshake.
REQ-006 SHALL have port key_valid, input, 1, master key offered.
REQ-007 SHALL have port key_ready, output, 1, block accepts a master key.
REQ-008 SHALL have port abort, input, 1, abandons the current schedule.
REQ-009 SHALL have port rk_out, output, 64, current round key.
REQ-010 SHALL have port rk_idx, output, 5, index of rk_out (0..NR).
REQ-011 SHALL have port rk_valid, output, 1, rk_out/rk_idx valid.
REQ-012 SHALL have port rk_ready, input, 1, consumer accepts round key.
REQ-013 SHALL have port rk_last, output, 1, high with rk_valid when rk_idx==NR.
REQ-014 SHALL have port busy, output, 1, high in RUN state.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 SHALL drive key_ready=1 in IDLE only; key handshake = key_valid & key_ready.
REQ-017 SHALL on key handshake load K<=key_in, idx<=0, go to RUN; RK0 presented with rk_valid=1 the next cycle.
REQ-018 SHALL in RUN drive rk_valid=1, rk_out=K[63:0], rk_idx=idx, rk_last=(idx==NR), all from registers.
REQ-019 SHALL hold K, idx and all rk_* outputs stable while rk_valid=1 and rk_ready=0.
REQ-020 SHALL on rk handshake with idx<NR update K<=F(K, idx+1) and idx<=idx+1.
REQ-021 SHALL on rk handshake with idx==NR return to IDLE; key_ready=1 the following cycle.
REQ-022 SHALL sustain one round key per cycle when rk_ready is held high: NR+1 keys in NR+1 consecutive cycles.
REQ-023 SHALL define F(K,rc) as follows: R = K rotated left by 13 over KEY_W bits; R[3:0] <= S(R[3:0]); R[63:59] <= R[63:59] ^ rc (5-bit).
REQ-024 SHALL additionally apply R[7:4] <= S(R[7:4]) when KEY_W==128 only.
REQ-025 SHALL use the BORON 4-bit S-box S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6} (hex, input 0..F).
REQ-026 SHALL pass all bits of K above bit 63 into the next K but never expose them on rk_out.
REQ-027 SHALL on abort=1 in RUN go to IDLE next cycle, clear idx, and discard K; abort takes priority over a simultaneous rk handshake (that key counts as delivered; no further keys follow).
REQ-028 SHALL ignore abort in IDLE; abort and key_valid together in IDLE loads the key.
REQ-029 SHALL ignore key_valid while in RUN (key_ready=0, no reload).
REQ-030 SHALL reject illegal KEY_W or NR at elaboration.

Reset
REQ-031 SHALL with reset_n=0 at a clock edge enter IDLE, set K=0, idx=0; outputs next cycle: key_ready=1, rk_valid=0, rk_last=0, busy=0, rk_out=0, rk_idx=0.
REQ-032 SHALL let reset mid-schedule override all other inputs, including abort and handshakes in that cycle.

Structure
REQ-033 SHALL place RK_W=64, RC_W=5, the FSM state type and the S-box table in shared package boron_pkg.
REQ-034 SHALL implement F as combinational sub-module boron_key_round (parameter KEY_W), instantiating the existing boron_gate S-box cell once or twice per KEY_W.
REQ-035 SHALL keep all registered state (K, idx, FSM) in boron_key_sched.

Verification
REQ-036 KEY_W=128, key_in=0, rk_ready=1 -> RK0=0x0000000000000000, RK1=0x08000000000000EE, rk_last only at idx 25, key_ready back 1 cycle after.
REQ-037 KEY_W=80, key_in=0, rk_ready=1 -> RK1=0x080000000000000E; 26 keys in 26 cycles.
REQ-038 128-bit random key, rk_ready toggled pseudo-randomly -> key sequence identical to rk_ready=1 run; outputs stable during stalls.
REQ-039 Abort at idx 7 together with rk_ready=1 -> idx 7 delivered, rk_valid=0 next cycle, key_ready=1; new key then starts at idx 0.
REQ-040 reset_n=0 at idx 12 -> next cycle all outputs at reset values; key_valid during RUN ignored (no reload observed).

Source files
------------

// File: rtl/boron_pkg.sv
// Shared definitions for the BORON key schedule: widths, FSM state type, S-box.
package boron_pkg;

    localparam int RK_W = 64;
    localparam int RC_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // BORON 4-bit S-box, element [i] is S(i): {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}
    localparam logic [15:0][3:0] SBOX = {
        4'h6, 4'h3, 4'h5, 4'h8, 4'hF, 4'h0, 4'h2, 4'hD,
        4'hA, 4'hC, 4'h9, 4'h7, 4'h1, 4'hB, 4'h4, 4'hE
    };

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/boron_gate.sv
// BORON S-box cell: one 4-bit substitution.
module boron_gate
    import boron_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);

    // Table lookup of the 4-bit substitution
    always_comb begin
        y = sbox_lookup(x);
    end

endmodule

// File: rtl/boron_key_round.sv
// One key-schedule step F(K, rc): rotate left 13, substitute the low nibble(s),
// and fold the round counter into bits 63:59.
module boron_key_round
    import boron_pkg::*;
#(
    parameter int KEY_W = 128
) (
    input  logic [KEY_W-1:0] k,
    input  logic [RC_W-1:0]  rc,
    output logic [KEY_W-1:0] k_next
);

    logic [KEY_W-1:0] rot_s;
    logic [3:0]       sb_lo_s;
    logic [3:0]       sb_hi_s;

    assign rot_s = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};

    boron_gate u_gate_lo (
        .x (rot_s[3:0]),
        .y (sb_lo_s)
    );

    // The 128-bit variant substitutes a second nibble; the 80-bit one passes it through
    if (KEY_W == 128) begin : g_sb_hi
        boron_gate u_gate_hi (
            .x (rot_s[7:4]),
            .y (sb_hi_s)
        );
    end else begin : g_no_sb_hi
        assign sb_hi_s = rot_s[7:4];
    end

    // Assemble the next key from the rotated word and the substituted fields
    always_comb begin
        k_next                          = rot_s;
        k_next[3:0]                     = sb_lo_s;
        k_next[7:4]                     = sb_hi_s;
        k_next[RK_W-1:RK_W-RC_W]        = rot_s[RK_W-1:RK_W-RC_W] ^ rc;
    end

endmodule

// File: rtl/boron_key_sched.sv
// BORON key scheduler: accepts a master key and streams round keys 0..NR
// over a valid/ready handshake, one key per cycle when the consumer is ready.
module boron_key_sched
    import boron_pkg::*;
#(
    parameter int KEY_W = 128,
    parameter int NR    = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             abort,
    output logic [RK_W-1:0]  rk_out,
    output logic [4:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             rk_last,
    output logic             busy
);

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("boron_key_sched: KEY_W must be 80 or 128");
    end
    if (NR < 1 || NR > 31) begin : g_bad_nr
        $error("boron_key_sched: NR must be in 1..31");
    end

    localparam logic [4:0] LAST_IDX = 5'(NR);

    sched_state_e     state_r;
    sched_state_e     state_nxt_s;
    logic [KEY_W-1:0] k_r;
    logic [KEY_W-1:0] k_nxt_s;
    logic [KEY_W-1:0] k_round_s;
    logic [4:0]       idx_r;
    logic [4:0]       idx_nxt_s;
    logic [RC_W-1:0]  rc_s;
    logic             rk_valid_r;
    logic             rk_last_r;
    logic             key_ready_r;
    logic             busy_r;

    assign rc_s = idx_r + 5'd1;

    boron_key_round #(.KEY_W(KEY_W)) u_round (
        .k      (k_r),
        .rc     (rc_s),
        .k_next (k_round_s)
    );

    // Next-state, next-key and next-index decision
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (key_valid) begin
                    state_nxt_s = ST_RUN;
                    k_nxt_s     = key_in;
                    idx_nxt_s   = 5'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // The key on offer this cycle counts as delivered; nothing follows
                    state_nxt_s = ST_IDLE;
                    k_nxt_s     = '0;
                    idx_nxt_s   = 5'd0;
                end else if (rk_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        k_nxt_s   = k_round_s;
                        idx_nxt_s = rc_s;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                k_nxt_s     = '0;
                idx_nxt_s   = 5'd0;
            end
        endcase
    end

    // State, key, index and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            k_r         <= '0;
            idx_r       <= 5'd0;
            rk_valid_r  <= 1'b0;
            rk_last_r   <= 1'b0;
            key_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            idx_r       <= idx_nxt_s;
            rk_valid_r  <= (state_nxt_s == ST_RUN);
            rk_last_r   <= (state_nxt_s == ST_RUN) && (idx_nxt_s == LAST_IDX);
            key_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s == ST_RUN);
        end
    end

    assign rk_out    = k_r[RK_W-1:0];
    assign rk_idx    = idx_r;
    assign rk_valid  = rk_valid_r;
    assign rk_last   = rk_last_r;
    assign key_ready = key_ready_r;
    assign busy      = busy_r;

endmodule
